// File: rtl/move_dir_selector_if.sv
// ---------------------------------------------------------------------------
// move_dir_selector_if
//   Groups the two handshakes of move_dir_selector into one bundle.
//   Score stream (evaluator -> selector):
//     s_valid  score beat present
//     s_ready  selector accepts a beat
//     s_score  W-bit unsigned score of the current direction
//     s_legal  1 = direction is a legal move
//   Result (selector -> ball-move controller):
//     m_valid  result present
//     m_ready  downstream accepts result
//     m_dir    selected direction index 0..7
//     m_score  score of the selected direction
//     m_none   1 = no legal direction was offered
//   Modports: slave = the selector itself, master = the environment around it.
// ---------------------------------------------------------------------------
interface move_dir_selector_if #(
  parameter int W = 8
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_score;
  logic         s_legal;
  logic         m_valid;
  logic         m_ready;
  logic [2:0]   m_dir;
  logic [W-1:0] m_score;
  logic         m_none;

  modport slave (
    input  s_valid, s_score, s_legal, m_ready,
    output s_ready, m_valid, m_dir, m_score, m_none
  );

  modport master (
    output s_valid, s_score, s_legal, m_ready,
    input  s_ready, m_valid, m_dir, m_score, m_none
  );
endinterface

// File: rtl/move_dir_selector.sv
// ---------------------------------------------------------------------------
// move_dir_selector
//   Collects 8 per-direction move scores serially and reports which legal
//   direction holds the highest unsigned score. Ties keep the lower index,
//   unless TIE_RANDOM_EN is defined, in which case an 8-bit Galois LFSR
//   (x^8+x^6+x^5+x^4+1, seed 8'h5A) decides whether an equal score replaces
//   the current best.
//   Ports:
//     clk    rising-edge system clock
//     rst    synchronous reset, active-high
//     start  begin a new evaluation (honoured only in IDLE)
//     busy   1 while collecting or holding a result
//     bus    move_dir_selector_if.slave (score stream in, result out)
//   Build option: `define TIE_RANDOM_EN enables random tie breaking.
// ---------------------------------------------------------------------------
module move_dir_selector #(
  parameter int W    = 8,
  parameter int NDIR = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  move_dir_selector_if.slave   bus
);

  localparam logic [2:0] LAST_DIR = 3'(NDIR - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [2:0]   cnt;
  logic [W-1:0] best;
  logic [2:0]   best_dir;
  logic         found;
  logic         accept;
  logic         take;

  assign accept = (state == COLLECT) && bus.s_valid;

`ifdef TIE_RANDOM_EN
  logic [7:0] lfsr;

  // Right-shifting Galois form; 8'hB8 is the tap mask for x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'h5A;
    else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  assign take = bus.s_legal &&
                (!found || (bus.s_score > best) ||
                 ((bus.s_score == best) && lfsr[0]));
`else
  // Strict '>' keeps the earlier (lower) index on equal scores.
  assign take = bus.s_legal && (!found || (bus.s_score > best));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      cnt      <= '0;
      best     <= '0;
      best_dir <= '0;
      found    <= 1'b0;
    end else if (accept) begin
      cnt <= (cnt == LAST_DIR) ? 3'd0 : cnt + 3'd1;
      if (take) begin
        best     <= bus.s_score;
        best_dir <= cnt;
        found    <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_dir   = '0;
    bus.m_score = '0;
    bus.m_none  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        busy        = 1'b1;
        bus.s_ready = 1'b1;
        if (accept && cnt == LAST_DIR) state_next = RESULT;
      end
      RESULT: begin
        busy        = 1'b1;
        bus.m_valid = 1'b1;
        // best/best_dir are still zero when nothing legal was seen.
        bus.m_dir   = best_dir;
        bus.m_score = best;
        bus.m_none  = !found;
        if (bus.m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_dir_selector.sv
// ---------------------------------------------------------------------------
// tb_move_dir_selector
//   Directed bench for move_dir_selector (default build, deterministic ties).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_move_dir_selector;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  move_dir_selector_if #(.W(8)) bus ();

  move_dir_selector #(.W(8), .NDIR(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),        32'd0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_dir"},   32'(bus.m_dir),   32'd0);
    check({tag, "_m_score"}, 32'(bus.m_score), 32'd0);
    check({tag, "_m_none"},  32'(bus.m_none),  32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one beat and hold it until the posedge that accepts it.
  task automatic send_beat(input logic [7:0] sc, input logic lg, input string tag);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_score = sc;
    bus.s_legal = lg;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_beat_timeout"}, 32'(n), 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // One full evaluation: scores packed with direction k in bits [8k+7:8k].
  // gap[k] inserts two idle cycles before beat k; start_noise pulses start
  // during a gap and during the held result; hold = cycles with m_ready low.
  task automatic run_eval(input string tag, input logic [63:0] sc, input logic [7:0] lg,
                          input logic [7:0] gap, input bit start_noise, input int hold,
                          input logic [2:0] e_dir, input logic [7:0] e_score,
                          input logic e_none);
    pulse_start();
    check({tag, "_busy_collect"}, 32'(busy),        32'd1);
    check({tag, "_s_ready"},      32'(bus.s_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (gap[k]) begin
        if (start_noise) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
      end
      send_beat(sc[8*k +: 8], lg[k], tag);
    end
    // Result must be up the cycle after the 8th accept.
    check({tag, "_m_valid_latency"}, 32'(bus.m_valid), 32'd1);
    check({tag, "_s_ready_result"},  32'(bus.s_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      check({tag, "_m_dir"},   32'(bus.m_dir),   32'(e_dir));
      check({tag, "_m_score"}, 32'(bus.m_score), 32'(e_score));
      check({tag, "_m_none"},  32'(bus.m_none),  32'(e_none));
      check({tag, "_m_valid_hold"}, 32'(bus.m_valid), 32'd1);
      if (start_noise && h == 1) begin
        start       = 1'b1;
        bus.s_valid = 1'b1;
      end else begin
        start       = 1'b0;
        bus.s_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, "_s_ready_hold"}, 32'(bus.s_ready), 32'd0);
    end
    start       = 1'b0;
    bus.s_valid = 1'b0;
    check({tag, "_m_dir_final"},   32'(bus.m_dir),   32'(e_dir));
    check({tag, "_m_score_final"}, 32'(bus.m_score), 32'(e_score));
    check({tag, "_m_none_final"},  32'(bus.m_none),  32'(e_none));
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check({tag, "_m_valid_drop"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_busy_idle"},    32'(busy),        32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_score = '0;
    bus.s_legal = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // T1: reset after three accepted beats aborts the evaluation.
    pulse_start();
    send_beat(8'd200, 1'b1, "t1");
    send_beat(8'd100, 1'b1, "t1");
    send_beat(8'd50,  1'b1, "t1");
    check("t1_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t1_abort");

    // T2: {3,9,1,4,9,2,0,7} all legal -> dir 1, score 9 (tie keeps dir 1).
    run_eval("t2", 64'h07_00_02_09_04_01_09_03, 8'hFF, 8'h00, 1'b0, 1,
             3'd1, 8'd9, 1'b0);

    // T3: {50,40,30,20,10,5,2,1}, only dir7 and dir1 legal -> dir 1, score 40.
    run_eval("t3", 64'h01_02_05_0A_14_1E_28_32, 8'b1000_0010, 8'h00, 1'b0, 1,
             3'd1, 8'd40, 1'b0);

    // T4: nothing legal -> m_none, dir 0, score 0.
    run_eval("t4", 64'h07_00_02_09_04_01_09_03, 8'h00, 8'h00, 1'b0, 1,
             3'd0, 8'd0, 1'b1);

    // T5: T2 scores with stalls, m_ready low for 5 cycles, stray start pulses.
    run_eval("t5", 64'h07_00_02_09_04_01_09_03, 8'hFF, 8'b0101_0110, 1'b1, 5,
             3'd1, 8'd9, 1'b0);

    // Legal zero score is a real winner when it is the only legal move.
    run_eval("zero_win", 64'h00_00_00_00_00_00_00_00, 8'b0010_0000, 8'h00, 1'b0, 1,
             3'd5, 8'd0, 1'b0);

    // Unsigned compare: 255 in the last slot beats 128 in the first.
    run_eval("max_last", 64'hFF_7F_01_80_00_10_20_80, 8'hFF, 8'h00, 1'b0, 1,
             3'd7, 8'd255, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
